// File: rtl/fifo_pop_pkg.sv
// Shared types and encodings for the main-FIFO pop arbiter.
package fifo_pop_pkg;

    // Pop-control FSM states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BLOCKED = 2'd1,
        RESUME  = 2'd2
    } pop_state_t;

    // BLOCK_MODE encodings: stall on any VC, or only on the head word's VC.
    localparam int BLK_ANY    = 0;
    localparam int BLK_TARGET = 1;

    // Width of the resume-delay counter (delays up to 15 cycles).
    localparam int RES_CNT_W  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count <= {CNT_W{1'b0}};
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1'b1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fifo_main_pop_arb.sv
// Drains a FWFT main FIFO into the VC-ID demux under per-VC almost-full
// backpressure, with resume hysteresis and per-VC pop counters.
module fifo_main_pop_arb
    import fifo_pop_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int NUM_VC     = 2,
    parameter int VC_LSB     = 4,
    parameter int VC_W       = 1,
    parameter int BLOCK_MODE = 0,
    parameter int RESUME_DLY = 2,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    Main_empty,
    input  logic [DATA_W-1:0]       Main_data_out,
    input  logic [NUM_VC-1:0]       VC_almost_full,
    output logic                    Main_rd,
    output logic [DATA_W-1:0]       demux_vcid_in,
    output logic                    demux_vcid_valid_in,
    output logic                    blocked,
    output logic [NUM_VC*CNT_W-1:0] pop_count
);

    localparam logic [RES_CNT_W-1:0] RESUME_INIT = RES_CNT_W'(RESUME_DLY);

    pop_state_t           state_r;
    pop_state_t           state_nxt_s;
    logic [RES_CNT_W-1:0] cnt_r;
    logic [RES_CNT_W-1:0] cnt_nxt_s;
    logic [31:0]          vc_s;
    logic                 any_af_s;
    logic                 tgt_af_s;
    logic                 blk_s;
    logic                 pop_s;
    logic [NUM_VC-1:0]    cnt_en_s;

    // Backpressure decode: any-VC stall, or head-target stall with a
    // conservative fallback for out-of-range VC IDs and an empty FIFO.
    always_comb begin
        any_af_s = |VC_almost_full;
        vc_s     = {{(32-VC_W){1'b0}}, Main_data_out[VC_LSB +: VC_W]};
        tgt_af_s = any_af_s;
        for (int i = 0; i < NUM_VC; i++) begin
            if (vc_s == i[31:0]) begin
                tgt_af_s = VC_almost_full[i];
            end else begin
                tgt_af_s = tgt_af_s;
            end
        end
        if ((BLOCK_MODE == BLK_TARGET) && !Main_empty) begin
            blk_s = tgt_af_s;
        end else begin
            blk_s = any_af_s;
        end
    end

    // FSM state and resume-delay counter register.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r <= RUN;
            cnt_r   <= {RES_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // FSM next-state: stall on backpressure, then wait RESUME_DLY clear
    // cycles before popping again so late almost-full updates can land.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (!Main_empty && blk_s) begin
                    state_nxt_s = BLOCKED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            BLOCKED: begin
                if (blk_s) begin
                    state_nxt_s = BLOCKED;
                end else if (RESUME_DLY == 0) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = RESUME;
                    cnt_nxt_s   = RESUME_INIT;
                end
            end
            RESUME: begin
                cnt_nxt_s = cnt_r - {{(RES_CNT_W-1){1'b0}}, 1'b1};
                if (blk_s) begin
                    state_nxt_s = BLOCKED;
                end else if (cnt_r == {{(RES_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = RESUME;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {RES_CNT_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: pop strobe and per-VC count enables.
    always_comb begin
        pop_s = reset_L && (state_r == RUN) && !Main_empty && !blk_s;
        for (int i = 0; i < NUM_VC; i++) begin
            cnt_en_s[i] = pop_s && (vc_s == i[31:0]);
        end
    end

    assign Main_rd = pop_s;
    assign blocked = (state_r != RUN);

    // Output register: forward the popped word, zero when idle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            demux_vcid_in       <= {DATA_W{1'b0}};
            demux_vcid_valid_in <= 1'b0;
        end else if (pop_s) begin
            demux_vcid_in       <= Main_data_out;
            demux_vcid_valid_in <= 1'b1;
        end else begin
            demux_vcid_in       <= {DATA_W{1'b0}};
            demux_vcid_valid_in <= 1'b0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset_L (reset_L),
                .en      (cnt_en_s[g]),
                .count   (pop_count[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fifo_main_pop_arb.sv
// Directed bench: dut_a = any-VC blocking, RESUME_DLY=2, 8-bit counters;
// dut_b = target-only blocking, RESUME_DLY=3, 3-bit counters.
module tb_fifo_main_pop_arb;

    logic             clk = 1'b0;
    logic             reset_L;
    logic [1:0]       empty;
    logic [1:0][5:0]  data;
    logic [1:0][1:0]  af;

    wire              rd_a, rd_b, val_a, val_b, blk_a, blk_b;
    wire [5:0]        dout_a, dout_b;
    wire [15:0]       pc_a;
    wire [5:0]        pc_b;

    logic [5:0] fifo_a[$];
    logic [5:0] fifo_b[$];
    logic [5:0] exp_a[$];
    logic [5:0] exp_b[$];

    int passed = 0;
    int total  = 0;
    int rdcnt_b = 0;

    always #5 clk = ~clk;

    fifo_main_pop_arb #(
        .DATA_W(6), .NUM_VC(2), .VC_LSB(4), .VC_W(1),
        .BLOCK_MODE(0), .RESUME_DLY(2), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset_L(reset_L), .Main_empty(empty[0]),
        .Main_data_out(data[0]), .VC_almost_full(af[0]),
        .Main_rd(rd_a), .demux_vcid_in(dout_a),
        .demux_vcid_valid_in(val_a), .blocked(blk_a), .pop_count(pc_a)
    );

    fifo_main_pop_arb #(
        .DATA_W(6), .NUM_VC(2), .VC_LSB(4), .VC_W(1),
        .BLOCK_MODE(1), .RESUME_DLY(3), .CNT_W(3)
    ) dut_b (
        .clk(clk), .reset_L(reset_L), .Main_empty(empty[1]),
        .Main_data_out(data[1]), .VC_almost_full(af[1]),
        .Main_rd(rd_b), .demux_vcid_in(dout_b),
        .demux_vcid_valid_in(val_b), .blocked(blk_b), .pop_count(pc_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Present the FIFO model heads to the DUTs and let logic settle.
    task automatic refresh();
        empty[0] = (fifo_a.size() == 0);
        data[0]  = empty[0] ? 6'd0 : fifo_a[0];
        empty[1] = (fifo_b.size() == 0);
        data[1]  = empty[1] ? 6'd0 : fifo_b[0];
        #1;
    endtask

    task automatic load_a(input logic [5:0] w);
        fifo_a.push_back(w);
        exp_a.push_back(w);
        refresh();
    endtask

    task automatic load_b(input logic [5:0] w);
        fifo_b.push_back(w);
        exp_b.push_back(w);
        refresh();
    endtask

    // One clock: sample pop strobes, advance, pop FIFO models, score outputs.
    task automatic cyc();
        logic ra, rb;
        ra = rd_a;
        rb = rd_b;
        if (rb) rdcnt_b++;
        @(posedge clk);
        #1;
        if (ra) void'(fifo_a.pop_front());
        if (rb) void'(fifo_b.pop_front());
        refresh();
        if (val_a) begin
            if (exp_a.size() == 0) check("sb_a_extra_valid", 32'd1, 32'd0);
            else check("sb_a_data", {26'd0, dout_a}, {26'd0, exp_a.pop_front()});
        end
        if (val_b) begin
            if (exp_b.size() == 0) check("sb_b_extra_valid", 32'd1, 32'd0);
            else check("sb_b_data", {26'd0, dout_b}, {26'd0, exp_b.pop_front()});
        end
    endtask

    initial begin
        reset_L = 1'b0;
        af      = '0;
        refresh();
        cyc();
        cyc();
        check("rst_valid_a", {31'd0, val_a}, 32'd0);
        check("rst_blocked_a", {31'd0, blk_a}, 32'd0);
        check("rst_dout_a", {26'd0, dout_a}, 32'd0);
        check("rst_pc_a", {16'd0, pc_a}, 32'd0);
        check("rst_pc_b", {26'd0, pc_b}, 32'd0);
        reset_L = 1'b1;
        refresh();

        // Test 1: four words stream out back-to-back.
        load_a(6'h03); load_a(6'h12); load_a(6'h21); load_a(6'h30);
        for (int i = 0; i < 4; i++) begin
            check("t1_rd", {31'd0, rd_a}, 32'd1);
            cyc();
        end
        check("t1_rd_empty", {31'd0, rd_a}, 32'd0);
        check("t1_sb_drained", exp_a.size(), 32'd0);
        check("t1_pc", {16'd0, pc_a}, {16'd0, 8'd2, 8'd2});
        cyc();
        check("t1_valid_idle", {31'd0, val_a}, 32'd0);

        // Test 2: any-VC blocking, then 1+2 cycles of hysteresis.
        af[0] = 2'b01;
        load_a(6'h15);
        check("t2_rd_blk", {31'd0, rd_a}, 32'd0);
        cyc();
        check("t2_blocked", {31'd0, blk_a}, 32'd1);
        cyc();
        af[0] = 2'b00;
        refresh();
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_blocked", {31'd0, blk_a}, 32'd1);
            check("t2_hold_rd", {31'd0, rd_a}, 32'd0);
            cyc();
        end
        check("t2_resumed", {31'd0, blk_a}, 32'd0);
        check("t2_rd", {31'd0, rd_a}, 32'd1);
        cyc();
        check("t2_sb_drained", exp_a.size(), 32'd0);
        cyc();

        // Test 5: empty FIFO never pops or blocks.
        for (int i = 0; i < 10; i++) begin
            check("t5_rd", {31'd0, rd_a}, 32'd0);
            check("t5_valid", {31'd0, val_a}, 32'd0);
            check("t5_blocked", {31'd0, blk_a}, 32'd0);
            cyc();
        end
        check("t5_pc", {16'd0, pc_a}, {16'd0, 8'd3, 8'd2});

        // Test 3: target-only blocking.
        af[1] = 2'b01;
        load_b(6'h15);
        load_b(6'h05);
        check("t3_rd_vc1", {31'd0, rd_b}, 32'd1);
        cyc();
        check("t3_rd_vc0", {31'd0, rd_b}, 32'd0);
        cyc();
        check("t3_blocked", {31'd0, blk_b}, 32'd1);
        cyc();
        check("t3_rd_held", {31'd0, rd_b}, 32'd0);
        af[1] = 2'b00;
        refresh();
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_blocked", {31'd0, blk_b}, 32'd1);
            check("t3_hold_rd", {31'd0, rd_b}, 32'd0);
            cyc();
        end
        check("t3_rd", {31'd0, rd_b}, 32'd1);
        cyc();
        check("t3_pc", {26'd0, pc_b}, {26'd0, 3'd1, 3'd1});

        // Test 4: backpressure returns during the 2nd RESUME cycle.
        rdcnt_b = 0;
        af[1] = 2'b01;
        load_b(6'h05);
        cyc();
        cyc();
        af[1] = 2'b00;
        refresh();
        cyc();
        cyc();
        af[1] = 2'b01;
        refresh();
        cyc();
        check("t4_reblocked", {31'd0, blk_b}, 32'd1);
        cyc();
        cyc();
        check("t4_no_rd", rdcnt_b, 32'd0);
        af[1] = 2'b00;
        refresh();
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_rd", {31'd0, rd_b}, 32'd0);
            cyc();
        end
        check("t4_rd", {31'd0, rd_b}, 32'd1);
        cyc();
        check("t4_pc", {26'd0, pc_b}, {26'd0, 3'd1, 3'd2});

        // Test 6: VC0 counter saturates at 7.
        for (int i = 0; i < 9; i++) load_b(6'(i));
        for (int i = 0; i < 9; i++) begin
            check("t6_rd", {31'd0, rd_b}, 32'd1);
            cyc();
        end
        check("t6_pc_sat", {26'd0, pc_b}, {26'd0, 3'd1, 3'd7});

        // Mid-stream reset with dut_b popping and dut_a blocked.
        load_b(6'h1a); load_b(6'h1b); load_b(6'h1c);
        af[0] = 2'b11;
        load_a(6'h01);
        cyc();
        cyc();
        check("t6_a_blocked_pre", {31'd0, blk_a}, 32'd1);
        reset_L = 1'b0;
        refresh();
        check("t6_rd_in_reset", {31'd0, rd_b}, 32'd0);
        cyc();
        fifo_a.delete(); exp_a.delete();
        fifo_b.delete(); exp_b.delete();
        refresh();
        check("t6_rst_valid", {31'd0, val_b}, 32'd0);
        check("t6_rst_dout", {26'd0, dout_b}, 32'd0);
        check("t6_rst_pc_b", {26'd0, pc_b}, 32'd0);
        check("t6_rst_pc_a", {16'd0, pc_a}, 32'd0);
        check("t6_rst_blocked_a", {31'd0, blk_a}, 32'd0);
        reset_L = 1'b1;
        af = '0;
        refresh();
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_main_pop_arb.md
Name: fifo_main_pop_arb

Overview:
Parametrised successor to the main-FIFO pop conditioner. It drains a first-word-fall-through main FIFO into the VC-ID demux under per-virtual-channel almost-full backpressure. It adds an N-channel generalisation, an optional target-only blocking mode, a resume-hysteresis FSM that covers almost-full lag, and per-VC pop counters. It sits between the Main FIFO read side and the VC demux input.

Parameters:
DATA_W, 6, width of Main FIFO word and demux input.
NUM_VC, 2, number of virtual channels / almost-full inputs (1..8).
VC_LSB, 4, bit position of the VC-ID field inside the data word.
VC_W, 1, width of the VC-ID field; VC_LSB+VC_W <= DATA_W.
BLOCK_MODE, 0, 0 = stall if any VC almost full (legacy); 1 = stall only if head word's target VC almost full.
RESUME_DLY, 2, cycles to wait after backpressure clears before popping resumes (0..15).
CNT_W, 8, width of each per-VC pop counter.

Ports:
clk  in  1  single clock, all state on posedge.
reset_L  in  1  synchronous, active-low reset.
Main_empty  in  1  Main FIFO empty flag.
Main_data_out  in  DATA_W  Main FIFO head word (FWFT, valid when !Main_empty).
VC_almost_full  in  NUM_VC  per-VC almost-full flags, bit i = VC i.
Main_rd  out  1  pop strobe, combinational; FIFO pops on the same posedge.
demux_vcid_in  out  DATA_W  registered popped word.
demux_vcid_valid_in  out  1  registered valid for demux_vcid_in.
blocked  out  1  high whenever FSM is not in RUN.
pop_count  out  NUM_VC*CNT_W  per-VC saturating pop counters, VC i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset_L=0 at posedge): state=RUN, resume counter=0, demux_vcid_in=0, demux_vcid_valid_in=0, all pop_count=0. Main_rd is forced 0 while reset_L=0.
- vc = Main_data_out[VC_LSB +: VC_W]. The value is out of range if vc >= NUM_VC.
- blk definition:
  - BLOCK_MODE=0: blk = OR of VC_almost_full.
  - BLOCK_MODE=1: blk = VC_almost_full[vc]. An out-of-range vc uses OR of all flags (conservative).
- pop = reset_L && state==RUN && !Main_empty && !blk. Main_rd = pop.
- Output register, updated every posedge:
  - demux_vcid_valid_in <= pop.
  - demux_vcid_in <= pop ? Main_data_out : 0.
  - Latency is one cycle from Main_rd to valid output. At most one pop per cycle; back-to-back pops are allowed.
- FSM states: RUN, BLOCKED, RESUME.
- RUN:
  - If !Main_empty && blk: go to BLOCKED, no pop.
  - If Main_empty: stay in RUN, no pop. An empty FIFO never causes BLOCKED.
- BLOCKED:
  - No pop. Evaluate blk against the current head word.
  - When blk=0 and RESUME_DLY=0: go to RUN.
  - When blk=0 and RESUME_DLY>0: go to RESUME with counter <= RESUME_DLY.
- RESUME:
  - No pop. Counter decrements each cycle.
  - If blk re-asserts: go to BLOCKED immediately.
  - If counter==1 and !blk: go to RUN.
  - RESUME therefore lasts exactly RESUME_DLY cycles; the first pop occurs in the following cycle.
- Blocking while Main_empty=1 in BLOCKED or RESUME: blk is still evaluated on the stale head. In BLOCK_MODE=1, the conservative OR-of-all is used while Main_empty=1.
- Counters: when pop occurs with an in-range vc, pop_count[vc] increments, saturating at all-ones. Out-of-range words are forwarded but not counted.
- Almost-full rising in the same cycle as a candidate pop: no pop (blk is combinational).
- Reset asserted mid-operation (any state, counter value): next cycle is the full reset state. No partial output; Main_rd=0 during that cycle.
- blocked = (state != RUN), decoded from the registered state.

Decomposition:
- Shared package fifo_pop_pkg holds:
  - the state enum (RUN=2'd0, BLOCKED=2'd1, RESUME=2'd2);
  - the BLOCK_MODE encodings BLK_ANY=0 and BLK_TARGET=1.
- One natural sub-module, sat_counter (CNT_W, increment enable, synchronous active-low reset), instantiated NUM_VC times via generate.
- The FSM and the output register stay in the top module.

Test Plan:
1. Reset, then 4 words 6'h03,6'h12,6'h21,6'h30 in FIFO with no almost-full -> Main_rd high 4 consecutive cycles; outputs valid one cycle later in the same order; pop_count VC0=2, VC1=2.
2. BLOCK_MODE=0, head 6'h15, VC_almost_full=2'b01 -> no pop, blocked=1. Clear flags -> blocked stays 1 for 1+2 cycles (BLOCKED exit plus RESUME_DLY=2), then 6'h15 pops.
3. BLOCK_MODE=1, head 6'h15 (VC1), VC_almost_full=2'b01 -> pops immediately. Next head 6'h05 (VC0) -> BLOCKED, no pop until bit0 clears.
4. RESUME_DLY=3: clear almost-full, re-assert it on the 2nd RESUME cycle -> FSM returns to BLOCKED; no Main_rd pulse occurs.
5. Main_empty=1 with all almost-full low for 10 cycles -> Main_rd=0, valid=0, blocked=0, counters unchanged.
6. CNT_W=3, pop 9 VC0 words -> pop_count VC0 saturates at 7. Assert reset_L=0 mid-stream -> all outputs 0 next cycle; Main_rd=0 during reset.
